reaction_sequencer: RTL and testbench



---
 rtl/reaction_sequencer_pkg.sv | 38 +++
 rtl/reaction_sequencer_lfsr.sv | 41 ++++
 rtl/reaction_sequencer.sv | 169 ++++++++++++++++
 tb/tb_reaction_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reaction_sequencer_pkg
//   Shared definitions for the reaction-time game sequencer:
//     - state_e      : round FSM states (3-bit encoding)
//     - LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11
//     - DEFAULT_SEED : power-on LFSR value
//     - lfsr_step    : one Galois shift of the 16-bit LFSR
//     - fix_seed     : maps an all-zero seed to 1 (all-zero is a lock-up state)
// ---------------------------------------------------------------------------
package reaction_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form: the bit falling out of bit 0 is folded
    // back into the tap positions.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/reaction_sequencer_lfsr.sv
// ---------------------------------------------------------------------------
// reaction_sequencer_lfsr
//   Free-running 16-bit Galois LFSR used to randomise the stimulus delay.
//   Loads SEED (zero replaced by 1) while reset is high, otherwise advances
//   once per tick. A non-zero state never steps to zero.
//
//   Ports:
//     tick_ms  in   1   1 kHz clock, posedge active
//     reset    in   1   synchronous, active-high
//     value    out  16  current LFSR state
// ---------------------------------------------------------------------------
module reaction_sequencer_lfsr
    import reaction_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        tick_ms,
    input  logic        reset,
    output logic [15:0] value
);

    localparam logic [15:0] SEED_EFF = fix_seed(SEED);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = lfsr_step(value_q);
    end

    always_ff @(posedge tick_ms) begin
        if (reset) begin
            value_q <= SEED_EFF;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/reaction_sequencer.sv
// ---------------------------------------------------------------------------
// reaction_sequencer
//   Runs one round of the reaction-time game. A rising edge on start latches
//   a pseudo-random delay (MIN_DELAY_MS + low RANGE_BITS of the LFSR), waits
//   that many ticks, then raises time_out until trigger is pressed or
//   MAX_WAIT_MS ticks elapse. Trigger during the wait is a false start.
//   All counts are in 1 ms ticks.
//
//   Ports:
//     tick_ms      in   1   1 kHz clock, posedge active
//     reset        in   1   synchronous, active-high
//     start        in   1   debounced start button (level)
//     trigger      in   1   debounced response button (level)
//     time_out     out  1   stimulus on
//     busy         out  1   round in progress (WAIT or GO)
//     false_start  out  1   sticky: trigger seen during WAIT
//     no_response  out  1   sticky: stimulus timed out
//     delay_ms     out  16  delay latched for the current round
// ---------------------------------------------------------------------------
module reaction_sequencer
    import reaction_sequencer_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RANGE_BITS   = 11,
    parameter int unsigned MAX_WAIT_MS  = 9999,
    parameter logic [15:0] LFSR_SEED    = DEFAULT_SEED
) (
    input  logic        tick_ms,
    input  logic        reset,
    input  logic        start,
    input  logic        trigger,
    output logic        time_out,
    output logic        busy,
    output logic        false_start,
    output logic        no_response,
    output logic [15:0] delay_ms
);

    localparam int unsigned MAX_DELAY    = MIN_DELAY_MS + (32'd1 << RANGE_BITS) - 32'd1;
    localparam logic [15:0] MIN_DELAY_16 = 16'(MIN_DELAY_MS);
    localparam logic [15:0] RANGE_MASK   = 16'((32'd1 << RANGE_BITS) - 32'd1);
    localparam logic [15:0] GO_LAST      = 16'(MAX_WAIT_MS - 32'd1);

    // Every delay and the stimulus window must fit the 16-bit counters.
    if (RANGE_BITS < 1 || RANGE_BITS > 15 || MAX_DELAY > 65535 ||
        MAX_WAIT_MS < 1 || MAX_WAIT_MS > 65535) begin : g_param_check
        $error("reaction_sequencer: parameters exceed 16-bit counter range");
    end

    logic [15:0] lfsr_val;

    reaction_sequencer_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .tick_ms (tick_ms),
        .reset   (reset),
        .value   (lfsr_val)
    );

    state_e      state_q,       state_d;
    logic        start_q,       start_d;
    logic        time_out_q,    time_out_d;
    logic        busy_q,        busy_d;
    logic        false_start_q, false_start_d;
    logic        no_response_q, no_response_d;
    logic [15:0] delay_q,       delay_d;
    logic [15:0] wait_cnt_q,    wait_cnt_d;
    logic [15:0] go_cnt_q,      go_cnt_d;

    logic        start_rise;
    logic [15:0] new_delay;

    assign start_rise = start & ~start_q;
    assign new_delay  = MIN_DELAY_16 + (lfsr_val & RANGE_MASK);

    always_comb begin
        state_d       = state_q;
        start_d       = start;
        time_out_d    = time_out_q;
        busy_d        = busy_q;
        false_start_d = false_start_q;
        no_response_d = no_response_q;
        delay_d       = delay_q;
        wait_cnt_d    = wait_cnt_q;
        go_cnt_d      = go_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start_rise) begin
                    delay_d       = new_delay;
                    // Loaded with D-1 so the stimulus lands exactly D ticks
                    // after the start edge.
                    wait_cnt_d    = new_delay - 16'd1;
                    false_start_d = 1'b0;
                    no_response_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (trigger) begin
                    state_d       = ST_FAULT;
                    false_start_d = 1'b1;
                    busy_d        = 1'b0;
                end else if (wait_cnt_q == '0) begin
                    state_d    = ST_GO;
                    time_out_d = 1'b1;
                    go_cnt_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end

            ST_GO: begin
                if (trigger) begin
                    state_d    = ST_DONE;
                    time_out_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (go_cnt_q == GO_LAST) begin
                    state_d       = ST_DONE;
                    time_out_d    = 1'b0;
                    busy_d        = 1'b0;
                    no_response_d = 1'b1;
                end else begin
                    go_cnt_d = go_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                time_out_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tick_ms) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            // Held-high start at reset release must not look like an edge.
            start_q       <= 1'b1;
            time_out_q    <= 1'b0;
            busy_q        <= 1'b0;
            false_start_q <= 1'b0;
            no_response_q <= 1'b0;
            delay_q       <= '0;
            wait_cnt_q    <= '0;
            go_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            time_out_q    <= time_out_d;
            busy_q        <= busy_d;
            false_start_q <= false_start_d;
            no_response_q <= no_response_d;
            delay_q       <= delay_d;
            wait_cnt_q    <= wait_cnt_d;
            go_cnt_q      <= go_cnt_d;
        end
    end

    assign time_out    = time_out_q;
    assign busy        = busy_q;
    assign false_start = false_start_q;
    assign no_response = no_response_q;
    assign delay_ms    = delay_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reaction_sequencer
//   Directed bench for reaction_sequencer with MIN_DELAY_MS=5, RANGE_BITS=2,
//   MAX_WAIT_MS=10. The stimulus process queues the expected output snapshot
//   {time_out, busy, false_start, no_response, delay_ms} for a given tick;
//   the monitor compares it on the falling edge of that tick.
// ---------------------------------------------------------------------------
module tb_reaction_sequencer;

    localparam int unsigned MIN  = 5;
    localparam int unsigned RB   = 2;
    localparam int unsigned MAXW = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        tick_ms = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b1;
    logic        trigger = 1'b0;
    logic        time_out;
    logic        busy;
    logic        false_start;
    logic        no_response;
    logic [15:0] delay_ms;

    reaction_sequencer #(
        .MIN_DELAY_MS (MIN),
        .RANGE_BITS   (RB),
        .MAX_WAIT_MS  (MAXW),
        .LFSR_SEED    (SEED)
    ) dut (
        .tick_ms     (tick_ms),
        .reset       (reset),
        .start       (start),
        .trigger     (trigger),
        .time_out    (time_out),
        .busy        (busy),
        .false_start (false_start),
        .no_response (no_response),
        .delay_ms    (delay_ms)
    );

    always #5 tick_ms = ~tick_ms;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [3:0]  flags;   // {time_out, busy, false_start, no_response}
        logic [15:0] dly;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc       = 0;
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    int unsigned bad_range = 0;
    int unsigned lfsr_zero = 0;
    logic [15:0] m_lfsr    = SEED;

    // Reference LFSR: right-shift Galois, polynomial x^16+x^14+x^13+x^11.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] fb;
        fb = s[0] ? 16'b1011_0100_0000_0000 : 16'h0000;
        return (s >> 1) ^ fb;
    endfunction

    always @(posedge tick_ms) begin
        cyc    <= cyc + 1;
        m_lfsr <= reset ? SEED : ref_step(m_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    // Monitor: compare every expectation scheduled for the tick just taken.
    always @(negedge tick_ms) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_flags"}, {28'd0, time_out, busy, false_start, no_response}, {28'd0, e.flags});
            chk({e.name, "_delay"}, {16'd0, delay_ms}, {16'd0, e.dly});
        end
        if (!reset && busy && (delay_ms < 16'(MIN) || delay_ms > 16'(MIN + (1 << RB) - 1)))
            bad_range++;
        if (!reset && dut.lfsr_val == 16'h0000)
            lfsr_zero++;
    end

    // Advance n ticks, returning 1 time unit after the last rising edge.
    task automatic tk(input int unsigned n);
        repeat (n) begin
            @(posedge tick_ms);
            #1;
        end
    endtask

    task automatic push_exp(input int unsigned k, input string name,
                            input logic [3:0] f, input int unsigned d);
        exp_t e;
        e.cyc   = cyc + k;
        e.name  = name;
        e.flags = f;
        e.dly   = 16'(d);
        sb.push_back(e);
    endtask

    // Delay the DUT will latch if start rises on the next edge.
    function automatic int unsigned next_delay();
        return MIN + int'(m_lfsr[RB-1:0]);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned d;

        // Reset with start held high throughout.
        tk(3);
        push_exp(0, "reset", 4'b0000, 0);
        reset = 1'b0;
        push_exp(1, "start_held_a", 4'b0000, 0);
        push_exp(4, "start_held_b", 4'b0000, 0);
        tk(4);
        start = 1'b0;
        tk(1);

        // Nominal round: trigger 6 ticks after the stimulus rises.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "nom_wait", 4'b0100, d);
        tk(1);
        start = 1'b0;
        push_exp(d - 1, "nom_pre_go", 4'b0100, d);
        push_exp(d, "nom_go", 4'b1100, d);
        tk(d);
        tk(5);
        trigger = 1'b1;
        push_exp(0, "nom_go_hold", 4'b1100, d);
        push_exp(1, "nom_done", 4'b0000, d);
        tk(1);
        trigger = 1'b0;
        tk(1);
        push_exp(0, "nom_done_hold", 4'b0000, d);

        // False start two ticks into the wait.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "fs_wait", 4'b0100, d);
        tk(1);
        start = 1'b0;
        tk(1);
        trigger = 1'b1;
        push_exp(1, "fs_fault", 4'b0010, d);
        tk(2);
        trigger = 1'b0;
        push_exp(0, "fs_hold", 4'b0010, d);
        tk(d);
        push_exp(0, "fs_no_stim", 4'b0010, d);

        // New round clears false_start, then runs out with no response.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "fs_clear", 4'b0100, d);
        tk(1);
        start = 1'b0;
        push_exp(d, "nr_go", 4'b1100, d);
        push_exp(d + 9, "nr_last", 4'b1100, d);
        push_exp(d + 10, "nr_done", 4'b0001, d);
        tk(d + 12);
        push_exp(0, "nr_hold", 4'b0001, d);

        // Trigger on the same tick the wait expires: false start wins.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "b1_wait", 4'b0100, d);
        tk(1);
        start = 1'b0;
        tk(d - 1);
        push_exp(0, "b1_pre", 4'b0100, d);
        trigger = 1'b1;
        push_exp(1, "b1_fault", 4'b0010, d);
        tk(1);
        trigger = 1'b0;
        tk(2);
        push_exp(0, "b1_hold", 4'b0010, d);

        // Trigger on the last stimulus tick: response wins over timeout.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "b2_wait", 4'b0100, d);
        tk(1);
        start = 1'b0;
        tk(d);
        push_exp(0, "b2_go", 4'b1100, d);
        tk(9);
        push_exp(0, "b2_pre", 4'b1100, d);
        trigger = 1'b1;
        push_exp(1, "b2_done", 4'b0000, d);
        tk(1);
        trigger = 1'b0;
        tk(2);
        push_exp(0, "b2_hold", 4'b0000, d);

        // Reset in the middle of the stimulus.
        start = 1'b1;
        d = next_delay();
        push_exp(1, "rst_wait", 4'b0100, d);
        tk(1);
        start = 1'b0;
        tk(d + 3);
        push_exp(0, "rst_pre", 4'b1100, d);
        reset = 1'b1;
        push_exp(1, "rst_go", 4'b0000, 0);
        tk(1);
        reset = 1'b0;
        tk(2);
        push_exp(0, "rst_idle", 4'b0000, 0);

        // Many short rounds: each ends as a false start on its first tick.
        for (int i = 0; i < 1000; i++) begin
            start = 1'b1;
            d = next_delay();
            push_exp(1, "rnd_wait", 4'b0100, d);
            tk(1);
            start   = 1'b0;
            trigger = 1'b1;
            push_exp(1, "rnd_fault", 4'b0010, d);
            tk(1);
            trigger = 1'b0;
        end

        tk(3);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        chk("delay_range", bad_range, 32'd0);
        chk("lfsr_nonzero", lfsr_zero, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
